// File: rtl/pmipsl_pkg.sv
// Shared types and encodings for the MIPS-L pipeline hazard controller.
package pmipsl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_CWAIT   = 2'd2,
        ST_RESOLVE = 2'd3
    } state_e;

    localparam logic [1:0] PC_HOLD  = 2'd0;
    localparam logic [1:0] PC_INC   = 2'd1;
    localparam logic [1:0] PC_REDIR = 2'd2;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // The younger producer (EX/MEM) wins when both stages hold the operand.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic wb_hit);
        if (ex_hit)      return FWD_EXMEM;
        else if (wb_hit) return FWD_MEMWB;
        else             return FWD_RF;
    endfunction

endpackage

// File: rtl/pmipsl_fwd_unit.sv
// ALU operand forwarding selects for the EX-stage instruction.
module pmipsl_fwd_unit
    import pmipsl_pkg::*;
#(
    parameter int unsigned RA_W = 3
) (
    input  logic [RA_W-1:0] idex_rs,
    input  logic [RA_W-1:0] idex_rt,
    input  logic            exmem_regwrite,
    input  logic [RA_W-1:0] exmem_wa,
    input  logic            memwb_regwrite,
    input  logic [RA_W-1:0] memwb_wa,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic ex_ok;
    logic wb_ok;

    // r0 is hard-wired zero, so writes to it are never forwarded.
    assign ex_ok = exmem_regwrite && (exmem_wa != '0);
    assign wb_ok = memwb_regwrite && (memwb_wa != '0);

    assign fwd_a = fwd_sel(ex_ok && (exmem_wa == idex_rs), wb_ok && (memwb_wa == idex_rs));
    assign fwd_b = fwd_sel(ex_ok && (exmem_wa == idex_rt), wb_ok && (memwb_wa == idex_rt));

endmodule

// File: rtl/pmipsl_hazard_ctrl.sv
// Pipeline sequencer: PC control, stage flush/hold strobes, load-use and control hazards.
// Define PMIPSL_FWD_EN to build with operand forwarding; otherwise data hazards stall.
module pmipsl_hazard_ctrl
    import pmipsl_pkg::*;
#(
    parameter int unsigned RA_W     = 3,
    parameter int unsigned CTRL_LAT = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            idex_memread,
    input  logic            idex_regwrite,
    input  logic [RA_W-1:0] idex_rs,
    input  logic [RA_W-1:0] idex_rt,
    input  logic [RA_W-1:0] idex_wa,
    input  logic            exmem_regwrite,
    input  logic [RA_W-1:0] exmem_wa,
    input  logic            mem_taken,
    input  logic            memwb_regwrite,
    input  logic [RA_W-1:0] memwb_wa,
    output logic [1:0]      pc_control,
    output logic            ifid_hold,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    localparam int unsigned CW = $clog2(CTRL_LAT) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(CTRL_LAT - 1);

    state_e         state;
    state_e         state_nx;
    logic [CW-1:0]  wait_cnt;
    logic [CW-1:0]  wait_nx;
    logic           load_use;
    logic           data_hz;
    logic           unused_inputs;

    assign load_use = idex_memread && (idex_wa != '0) &&
                      ((idex_wa == id_rs) || (id_uses_rt && (idex_wa == id_rt)));

`ifdef PMIPSL_FWD_EN
    assign data_hz       = 1'b0;
    assign unused_inputs = idex_regwrite;

    pmipsl_fwd_unit #(.RA_W(RA_W)) u_fwd (
        .idex_rs        (idex_rs),
        .idex_rt        (idex_rt),
        .exmem_regwrite (exmem_regwrite),
        .exmem_wa       (exmem_wa),
        .memwb_regwrite (memwb_regwrite),
        .memwb_wa       (memwb_wa),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );
`else
    // Without forwarding, any in-flight EX or MEM producer of an ID source stalls issue.
    assign data_hz = (idex_regwrite && (idex_wa != '0) &&
                      ((idex_wa == id_rs) || (idex_wa == id_rt))) ||
                     (exmem_regwrite && (exmem_wa != '0) &&
                      ((exmem_wa == id_rs) || (exmem_wa == id_rt)));
    assign fwd_a         = FWD_RF;
    assign fwd_b         = FWD_RF;
    assign unused_inputs = ^{idex_rs, idex_rt, memwb_regwrite, memwb_wa};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wait_nx    = wait_cnt;
        pc_control = PC_INC;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        case (state)
            ST_RUN, ST_LDSTALL: begin
                state_nx = ST_RUN;
                if ((state == ST_RUN) && load_use) begin
                    pc_control = PC_HOLD;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                    state_nx   = ST_LDSTALL;
                end else if (data_hz) begin
                    pc_control = PC_HOLD;
                    ifid_hold  = 1'b1;
                    idex_flush = 1'b1;
                end else if (id_branch || id_jump) begin
                    pc_control = PC_HOLD;
                    ifid_flush = 1'b1;
                    wait_nx    = CNT_INIT;
                    state_nx   = (CTRL_LAT <= 1) ? ST_RESOLVE : ST_CWAIT;
                end
            end
            ST_CWAIT: begin
                pc_control = PC_HOLD;
                ifid_flush = 1'b1;
                wait_nx    = wait_cnt - CW'(1);
                if (wait_cnt <= CW'(1)) begin
                    state_nx = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_nx = ST_RUN;
                if (mem_taken) begin
                    pc_control = PC_REDIR;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            default: state_nx = ST_RUN;
        endcase
        // Outputs track reset immediately rather than waiting for the state register.
        if (!reset) begin
            pc_control = PC_INC;
            ifid_hold  = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
        end
    end

endmodule

// File: tb/tb_pmipsl_hazard_ctrl.sv
// Self-checking bench for pmipsl_hazard_ctrl; follows PMIPSL_FWD_EN like the design.
module tb_pmipsl_hazard_ctrl;

    localparam int RA_W     = 3;
    localparam int CTRL_LAT = 2;
`ifdef PMIPSL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            id_branch, id_jump, id_uses_rt;
    logic [RA_W-1:0] id_rs, id_rt;
    logic            idex_memread, idex_regwrite;
    logic [RA_W-1:0] idex_rs, idex_rt, idex_wa;
    logic            exmem_regwrite, mem_taken, memwb_regwrite;
    logic [RA_W-1:0] exmem_wa, memwb_wa;
    logic [1:0]      pc_control, fwd_a, fwd_b;
    logic            ifid_hold, ifid_flush, idex_flush;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clock = ~clock;

    pmipsl_hazard_ctrl #(.RA_W(RA_W), .CTRL_LAT(CTRL_LAT)) dut (
        .clock          (clock),
        .reset          (reset),
        .id_branch      (id_branch),
        .id_jump        (id_jump),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .idex_memread   (idex_memread),
        .idex_regwrite  (idex_regwrite),
        .idex_rs        (idex_rs),
        .idex_rt        (idex_rt),
        .idex_wa        (idex_wa),
        .exmem_regwrite (exmem_regwrite),
        .exmem_wa       (exmem_wa),
        .mem_taken      (mem_taken),
        .memwb_regwrite (memwb_regwrite),
        .memwb_wa       (memwb_wa),
        .pc_control     (pc_control),
        .ifid_hold      (ifid_hold),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since a branch/jump was seen in ID, and whether
    // the previous cycle was a load-use bubble.
    int m_age  = 0;
    bit m_ld   = 1'b0;
    int nx_age = 0;
    bit nx_ld  = 1'b0;

    function automatic bit hit(input logic [RA_W-1:0] wa, input logic [RA_W-1:0] src);
        return (wa != 0) && (wa == src);
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [RA_W-1:0] src);
        if (!FWD) return 2'b00;
        if (exmem_regwrite && hit(exmem_wa, src)) return 2'b10;
        if (memwb_regwrite && hit(memwb_wa, src)) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_age = 0;
            m_ld  = 1'b0;
        end else begin
            m_age = nx_age;
            m_ld  = nx_ld;
        end
    end

    always @(negedge clock) begin
        logic [1:0] e_pc;
        logic       e_h, e_fi, e_fd;
        bit         lu, dh;
        e_pc = 2'd1; e_h = 1'b0; e_fi = 1'b0; e_fd = 1'b0;
        nx_age = 0; nx_ld = 1'b0;
        if (reset) begin
            if (m_age == CTRL_LAT) begin
                if (mem_taken) begin e_pc = 2'd2; e_fi = 1'b1; e_fd = 1'b1; end
            end else if (m_age > 0) begin
                e_pc = 2'd0; e_fi = 1'b1; nx_age = m_age + 1;
            end else begin
                lu = !m_ld && idex_memread &&
                     (hit(idex_wa, id_rs) || (id_uses_rt && hit(idex_wa, id_rt)));
                dh = !FWD && ((idex_regwrite && (hit(idex_wa, id_rs) || hit(idex_wa, id_rt))) ||
                              (exmem_regwrite && (hit(exmem_wa, id_rs) || hit(exmem_wa, id_rt))));
                if (lu || dh) begin
                    e_pc = 2'd0; e_h = 1'b1; e_fd = 1'b1; nx_ld = lu;
                end else if (id_branch || id_jump) begin
                    e_pc = 2'd0; e_fi = 1'b1; nx_age = 1;
                end
            end
        end
        chk("model.pc_control", pc_control, e_pc);
        chk("model.ifid_hold", {1'b0, ifid_hold}, {1'b0, e_h});
        chk("model.ifid_flush", {1'b0, ifid_flush}, {1'b0, e_fi});
        chk("model.idex_flush", {1'b0, idex_flush}, {1'b0, e_fd});
        chk("model.fwd_a", fwd_a, fwd_exp(idex_rs));
        chk("model.fwd_b", fwd_b, fwd_exp(idex_rt));
    end

    task automatic clear();
        id_branch = 0; id_jump = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
        idex_memread = 0; idex_regwrite = 0; idex_rs = 0; idex_rt = 0; idex_wa = 0;
        exmem_regwrite = 0; exmem_wa = 0; mem_taken = 0; memwb_regwrite = 0; memwb_wa = 0;
    endtask

    // Hand-computed expectations for one cycle; inputs are already applied.
    task automatic tick(input string name, input logic [1:0] pc, input logic h, input logic fi,
                        input logic fd, input logic [1:0] fa, input logic [1:0] fb);
        @(negedge clock);
        chk({name, ".pc"}, pc_control, pc);
        chk({name, ".hold"}, {1'b0, ifid_hold}, {1'b0, h});
        chk({name, ".ifid_flush"}, {1'b0, ifid_flush}, {1'b0, fi});
        chk({name, ".idex_flush"}, {1'b0, idex_flush}, {1'b0, fd});
        chk({name, ".fwd_a"}, fwd_a, fa);
        chk({name, ".fwd_b"}, fwd_b, fb);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        id_branch = 1;
        @(posedge clock); #1;
        tick("reset", 2'd1, 0, 0, 0, 2'd0, 2'd0);
        clear();
        reset = 1'b1;
        tick("idle", 2'd1, 0, 0, 0, 2'd0, 2'd0);

        // lw r2 ; add r3,r2,r1
        idex_memread = 1; idex_regwrite = 1; idex_wa = 2; id_rs = 2; id_rt = 1; id_uses_rt = 1;
        tick("lu_stall", 2'd0, 1, 0, 1, 2'd0, 2'd0);
        idex_memread = 0; idex_regwrite = 0; idex_wa = 0; exmem_regwrite = 1; exmem_wa = 2;
        tick("lu_next", FWD ? 2'd1 : 2'd0, !FWD, 0, !FWD, 2'd0, 2'd0);
        exmem_regwrite = 0; exmem_wa = 0; memwb_regwrite = 1; memwb_wa = 2; idex_rs = 2; idex_rt = 1;
        tick("lu_issue", 2'd1, 0, 0, 0, FWD ? 2'b01 : 2'b00, 2'd0);

        // r0 destination and unused rt never raise a load-use stall
        clear(); idex_memread = 1; idex_wa = 0; id_rs = 0;
        tick("lu_r0", 2'd1, 0, 0, 0, 2'd0, 2'd0);
        clear(); idex_memread = 1; idex_regwrite = 1; idex_wa = 3; id_rs = 1; id_rt = 3;
        tick("lu_rt_unused", FWD ? 2'd1 : 2'd0, !FWD, 0, !FWD, 2'd0, 2'd0);

        // beq not taken, with hazard inputs ignored while waiting
        clear(); id_branch = 1;
        tick("nt_detect", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        clear(); id_branch = 1; idex_memread = 1; idex_regwrite = 1; idex_wa = 5; id_rs = 5;
        tick("nt_wait", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        clear();
        tick("nt_resolve", 2'd1, 0, 0, 0, 2'd0, 2'd0);
        tick("nt_run", 2'd1, 0, 0, 0, 2'd0, 2'd0);

        // j taken; redirect beats a simultaneous load-use pattern
        clear(); id_jump = 1;
        tick("j_detect", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        clear();
        tick("j_wait", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        mem_taken = 1; idex_memread = 1; idex_wa = 5; id_rs = 5;
        tick("j_resolve", 2'd2, 0, 1, 1, 2'd0, 2'd0);
        clear();
        tick("j_run", 2'd1, 0, 0, 0, 2'd0, 2'd0);

        // branch behind a load: stall first, then control detect
        id_branch = 1; idex_memread = 1; idex_regwrite = 1; idex_wa = 4; id_rs = 4;
        tick("bl_stall", 2'd0, 1, 0, 1, 2'd0, 2'd0);
        clear(); id_branch = 1; id_rs = 4;
        tick("bl_detect", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        clear();
        tick("bl_wait", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        mem_taken = 1;
        tick("bl_resolve", 2'd2, 0, 1, 1, 2'd0, 2'd0);
        clear();

        // forwarding select priority and r0
        idex_rs = 1; exmem_regwrite = 1; exmem_wa = 1;
        tick("fwd_ex", 2'd1, 0, 0, 0, FWD ? 2'b10 : 2'b00, 2'd0);
        exmem_regwrite = 0; memwb_regwrite = 1; memwb_wa = 1;
        tick("fwd_wb", 2'd1, 0, 0, 0, FWD ? 2'b01 : 2'b00, 2'd0);
        exmem_regwrite = 1; idex_rt = 1;
        tick("fwd_both", 2'd1, 0, 0, 0, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
        idex_rs = 0; idex_rt = 0; exmem_wa = 0; memwb_wa = 0;
        tick("fwd_r0", 2'd1, 0, 0, 0, 2'd0, 2'd0);

        // add r1 ; add r4,r1,r1
        clear(); idex_regwrite = 1; idex_wa = 1; id_rs = 1; id_rt = 1; id_uses_rt = 1;
        tick("dh_ex", FWD ? 2'd1 : 2'd0, !FWD, 0, !FWD, 2'd0, 2'd0);
        idex_regwrite = 0; idex_wa = 0; exmem_regwrite = 1; exmem_wa = 1;
        tick("dh_mem", FWD ? 2'd1 : 2'd0, !FWD, 0, !FWD, 2'd0, 2'd0);
        exmem_regwrite = 0; exmem_wa = 0; memwb_regwrite = 1; memwb_wa = 1;
        tick("dh_issue", 2'd1, 0, 0, 0, 2'd0, 2'd0);

        // reset during CWAIT drops the pending redirect
        clear(); id_jump = 1;
        tick("rw_detect", 2'd0, 0, 1, 0, 2'd0, 2'd0);
        clear(); reset = 1'b0;
        #1;
        chk("rw_async.pc", pc_control, 2'd1);
        chk("rw_async.ifid_flush", {1'b0, ifid_flush}, 2'd0);
        @(posedge clock); #1;
        reset = 1'b1; mem_taken = 1;
        tick("rw_after", 2'd1, 0, 0, 0, 2'd0, 2'd0);
        clear();
        tick("rw_run", 2'd1, 0, 0, 0, 2'd0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
